heap_pq_unit: RTL and testbench

- Parametrised binary-heap priority queue exposed as a custom-instruction functional unit.
- Successor to the fixed 25-entry, 32-bit max-heap unit. Adds:
  - configurable data width, depth and min/max ordering
  - a valid/ready command handshake
  - peek and replace (pop+push) operations
  - error reporting and an occupancy count
- Sits beside the vector datapath. The core issues a command, and the unit returns a registered result tagged with the issuing rd.

---
 rtl/heap_pq_pkg.sv | 24 ++
 rtl/heap_pq_if.sv | 30 +++
 rtl/heap_pq_cmp.sv | 21 ++
 rtl/heap_pq_unit.sv | 254 +++++++++++++++++++++++++
 tb/tb_heap_pq_unit.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/heap_pq_pkg.sv
// heap_pq_pkg: shared definitions for the heap priority-queue unit.
//   - command opcodes carried on in_op
//   - FSM state encoding
//   - idx_w(): width of the heap index datapath, wide enough to hold
//     2*idx+2 for any idx < DEPTH without wrapping
package heap_pq_pkg;

  localparam logic [1:0] OP_PUSH    = 2'b00;
  localparam logic [1:0] OP_POP     = 2'b01;
  localparam logic [1:0] OP_PEEK    = 2'b10;
  localparam logic [1:0] OP_REPLACE = 2'b11;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SIFT_UP   = 2'd1,
    SIFT_DOWN = 2'd2
  } state_e;

  // One bit more than the count width: 2*(DEPTH-1)+2 = 2*DEPTH < 2^(CW+1).
  function automatic int idx_w(input int depth);
    return $clog2(depth + 1) + 1;
  endfunction

endpackage

// File: rtl/heap_pq_if.sv
// heap_pq_if: command/result bundle between the issuing core (master) and
// the heap unit (slave).
//   in_v/in_ready   command handshake, in_op/in_rd/in_data command payload
//   out_v           one-cycle result strobe, out_rd/out_data/out_err result
interface heap_pq_if #(
  parameter int DW = 32
);
  import heap_pq_pkg::*;

  logic          in_v;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [4:0]    in_rd;
  logic [DW-1:0] in_data;
  logic          out_v;
  logic [4:0]    out_rd;
  logic [DW-1:0] out_data;
  logic          out_err;

  modport master (
    output in_v, in_op, in_rd, in_data,
    input  in_ready, out_v, out_rd, out_data, out_err
  );

  modport slave (
    input  in_v, in_op, in_rd, in_data,
    output in_ready, out_v, out_rd, out_data, out_err
  );

endinterface

// File: rtl/heap_pq_cmp.sv
// heap_pq_cmp: combinational priority compare.
//   a, b   elements to compare
//   beats  1 when a has strictly higher priority than b
//          (a > b for a max-heap, a < b for a min-heap). Equal values never
//          beat each other, so equal elements are never swapped.
module heap_pq_cmp #(
  parameter int DW       = 32,
  parameter int MIN_MODE = 0
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          beats
);

  if (MIN_MODE != 0) begin : g_min
    assign beats = (a < b);
  end else begin : g_max
    assign beats = (a > b);
  end

endmodule

// File: rtl/heap_pq_unit.sv
// heap_pq_unit: binary-heap priority queue functional unit.
//   clk, reset        clock, synchronous active-high reset
//   bus (slave)       command handshake in, registered tagged result out
//   count/empty/full  occupancy, updated the cycle after acceptance
// Optional macro HEAP_PQ_STATS_EN adds:
//   hwm               high-water mark of count since reset
//   err_cnt           saturating count of out_err result pulses
// Commands are taken only in IDLE; PUSH then sifts up and POP/REPLACE sift
// down, one compare/swap per cycle. Heap storage is never cleared.
module heap_pq_unit
  import heap_pq_pkg::*;
#(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int MIN_MODE = 0,
  parameter int CW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  heap_pq_if.slave      bus,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
`ifdef HEAP_PQ_STATS_EN
  ,
  output logic [CW-1:0] hwm,
  output logic [15:0]   err_cnt
`endif
);

  localparam int IW = idx_w(DEPTH);
  localparam int AW = $clog2(DEPTH);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [CW-1:0] count_q, count_d;
  logic          out_v_q, out_v_d;
  logic          out_err_q, out_err_d;
  logic [4:0]    out_rd_q, out_rd_d;
  logic [DW-1:0] out_data_q, out_data_d;

  logic [DW-1:0] heap_q [DEPTH];

  // Two write ports: a swap moves both elements in one cycle.
  logic          wa_en, wb_en;
  logic [AW-1:0] wa_idx, wb_idx;
  logic [DW-1:0] wa_dat, wb_dat;

  logic          is_empty, is_full;
  logic [IW-1:0] par_i, lc_i, rc_i, child_i, cnt_x;
  logic [DW-1:0] cur_v, par_v, l_v, r_v, best_v, child_v, root_v, last_v;
  logic          l_ok, r_ok, up_beats, l_beats, r_beats, sel_l, sel_r;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign cnt_x    = IW'(count_q);

  assign par_i = (idx_q - IW'(1)) >> 1;
  assign lc_i  = (idx_q << 1) + IW'(1);
  assign rc_i  = (idx_q << 1) + IW'(2);
  assign l_ok  = (lc_i < cnt_x);
  assign r_ok  = (rc_i < cnt_x);

  // Out-of-range child reads are harmless: they are masked by l_ok/r_ok.
  assign cur_v  = heap_q[AW'(idx_q)];
  assign par_v  = heap_q[AW'(par_i)];
  assign l_v    = heap_q[AW'(lc_i)];
  assign r_v    = heap_q[AW'(rc_i)];
  assign root_v = heap_q[0];
  assign last_v = heap_q[AW'(count_q - CW'(1))];

  heap_pq_cmp #(.DW(DW), .MIN_MODE(MIN_MODE)) u_cmp_up (
    .a(cur_v), .b(par_v), .beats(up_beats)
  );
  heap_pq_cmp #(.DW(DW), .MIN_MODE(MIN_MODE)) u_cmp_l (
    .a(l_v), .b(cur_v), .beats(l_beats)
  );
  // Right must strictly beat the better of {idx, left}, so left wins ties.
  heap_pq_cmp #(.DW(DW), .MIN_MODE(MIN_MODE)) u_cmp_r (
    .a(r_v), .b(best_v), .beats(r_beats)
  );

  assign sel_l   = l_ok && l_beats;
  assign best_v  = sel_l ? l_v : cur_v;
  assign sel_r   = r_ok && r_beats;
  assign child_i = sel_r ? rc_i : lc_i;
  assign child_v = sel_r ? r_v : l_v;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    count_d    = count_q;
    out_v_d    = 1'b0;
    out_rd_d   = out_rd_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    wa_en      = 1'b0;
    wa_idx     = '0;
    wa_dat     = '0;
    wb_en      = 1'b0;
    wb_idx     = '0;
    wb_dat     = '0;

    case (state_q)
      IDLE: begin
        if (bus.in_v) begin
          out_v_d    = 1'b1;
          out_rd_d   = bus.in_rd;
          out_err_d  = 1'b0;
          out_data_d = '0;
          case (bus.in_op)
            OP_PUSH: begin
              if (is_full) begin
                out_err_d = 1'b1;
              end else begin
                wa_en      = 1'b1;
                wa_idx     = AW'(count_q);
                wa_dat     = bus.in_data;
                count_d    = count_q + CW'(1);
                idx_d      = IW'(count_q);
                state_d    = SIFT_UP;
                out_data_d = bus.in_data;
              end
            end
            OP_POP: begin
              if (is_empty) begin
                out_err_d = 1'b1;
              end else begin
                out_data_d = root_v;
                wa_en      = 1'b1;
                wa_dat     = last_v;
                count_d    = count_q - CW'(1);
                idx_d      = '0;
                state_d    = (count_q == CW'(1)) ? IDLE : SIFT_DOWN;
              end
            end
            OP_PEEK: begin
              if (is_empty) out_err_d = 1'b1;
              else          out_data_d = root_v;
            end
            default: begin
              // REPLACE on an empty heap degrades to a flagged PUSH at slot 0.
              if (is_empty) begin
                out_err_d = 1'b1;
                wa_en     = 1'b1;
                wa_dat    = bus.in_data;
                count_d   = CW'(1);
                idx_d     = '0;
                state_d   = SIFT_UP;
              end else begin
                out_data_d = root_v;
                wa_en      = 1'b1;
                wa_dat     = bus.in_data;
                idx_d      = '0;
                state_d    = SIFT_DOWN;
              end
            end
          endcase
        end
      end

      SIFT_UP: begin
        if (idx_q != '0 && up_beats) begin
          wa_en   = 1'b1;
          wa_idx  = AW'(idx_q);
          wa_dat  = par_v;
          wb_en   = 1'b1;
          wb_idx  = AW'(par_i);
          wb_dat  = cur_v;
          idx_d   = par_i;
        end else begin
          state_d = IDLE;
        end
      end

      SIFT_DOWN: begin
        if (sel_l || sel_r) begin
          wa_en   = 1'b1;
          wa_idx  = AW'(idx_q);
          wa_dat  = child_v;
          wb_en   = 1'b1;
          wb_idx  = AW'(child_i);
          wb_dat  = cur_v;
          idx_d   = child_i;
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      count_q    <= '0;
      out_v_q    <= 1'b0;
      out_rd_q   <= '0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      out_v_q    <= out_v_d;
      out_rd_q   <= out_rd_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (wa_en) heap_q[wa_idx] <= wa_dat;
      if (wb_en) heap_q[wb_idx] <= wb_dat;
    end
  end

  assign bus.in_ready = (state_q == IDLE);
  assign bus.out_v    = out_v_q;
  assign bus.out_rd   = out_rd_q;
  assign bus.out_data = out_data_q;
  assign bus.out_err  = out_err_q;
  assign count        = count_q;
  assign empty        = is_empty;
  assign full         = is_full;

`ifdef HEAP_PQ_STATS_EN
  logic [CW-1:0] hwm_q, hwm_d;
  logic [15:0]   err_cnt_q, err_cnt_d;

  always_comb begin
    hwm_d     = (count_d > hwm_q) ? count_d : hwm_q;
    err_cnt_d = err_cnt_q;
    if (out_v_q && out_err_q && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hwm_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      hwm_q     <= hwm_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign hwm     = hwm_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_heap_pq_unit.sv
// tb_heap_pq_unit: drives identical command streams into a max-heap
// (DEPTH 8) and a min-heap (DEPTH 4). Each unit has an unordered multiset
// reference model; accepted commands push expected results into a per-unit
// queue which a negedge monitor pops against out_v.
module tb_heap_pq_unit;
  import heap_pq_pkg::*;

  localparam int DW = 32;
  localparam int NG = 2;

  typedef struct {
    logic [4:0]    rd;
    logic [DW-1:0] data;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          in_v = 1'b0;
  logic [1:0]    in_op = 2'b00;
  logic [4:0]    in_rd = '0;
  logic [DW-1:0] in_data = '0;

  logic [NG-1:0] rdy_w, ov_w, oerr_w, emp_w, ful_w;
  logic [4:0]    ord_w [NG];
  logic [DW-1:0] od_w [NG];
  int            cnt_w [NG];

  int chk  = 0;
  int errs = 0;
  bit tmo  = 1'b0;
  bit done = 1'b0;

  for (genvar g = 0; g < NG; g++) begin : g_dut
    localparam int D  = (g == 0) ? 8 : 4;
    localparam int CW = $clog2(D + 1);
    heap_pq_if #(.DW(DW)) bus ();
    logic [CW-1:0] count;
    logic          empty, full;
`ifdef HEAP_PQ_STATS_EN
    logic [CW-1:0] hwm;
    logic [15:0]   err_cnt;
`endif
    heap_pq_unit #(.DW(DW), .DEPTH(D), .MIN_MODE(g)) u_dut (
      .clk(clk), .reset(rst), .bus(bus),
      .count(count), .empty(empty), .full(full)
`ifdef HEAP_PQ_STATS_EN
      , .hwm(hwm), .err_cnt(err_cnt)
`endif
    );
    assign bus.in_v    = in_v;
    assign bus.in_op   = in_op;
    assign bus.in_rd   = in_rd;
    assign bus.in_data = in_data;
    assign rdy_w[g]    = bus.in_ready;
    assign ov_w[g]     = bus.out_v;
    assign oerr_w[g]   = bus.out_err;
    assign ord_w[g]    = bus.out_rd;
    assign od_w[g]     = bus.out_data;
    assign emp_w[g]    = empty;
    assign ful_w[g]    = full;
    assign cnt_w[g]    = int'(count);
  end

  task automatic ck(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    chk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s dut%0d got %0h want %0h @%0t", nm, g, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [DW-1:0] mq [NG][$];
  exp_t          eq [NG][$];
  int            busy [NG];
  bit            rst_d = 1'b0;
  bit            fin = 1'b0;
  exp_t          e;
  int            sz, bi, dep, lim;

  always @(negedge clk) begin
    for (int g = 0; g < NG; g++) begin
      dep = (g == 0) ? 8 : 4;
      lim = (g == 0) ? 4 : 3;
      if (rst_d) begin
        ck("rst_out_v", g, 32'(ov_w[g]), 0);
        ck("rst_ready", g, 32'(rdy_w[g]), 1);
        ck("rst_empty", g, 32'(emp_w[g]), 1);
        ck("rst_full", g, 32'(ful_w[g]), 0);
        ck("rst_count", g, cnt_w[g], 0);
        ck("rst_err", g, 32'(oerr_w[g]), 0);
        ck("rst_data", g, od_w[g], 0);
        ck("rst_rd", g, 32'(ord_w[g]), 0);
        busy[g] = 0;
      end else begin
        if (ov_w[g]) begin
          if (eq[g].size() == 0) begin
            ck("unexpected_out_v", g, 1, 0);
          end else begin
            e = eq[g].pop_front();
            ck("out_rd", g, 32'(ord_w[g]), 32'(e.rd));
            ck("out_err", g, 32'(oerr_w[g]), 32'(e.err));
            ck("out_data", g, od_w[g], e.data);
          end
        end else if (eq[g].size() != 0) begin
          e = eq[g].pop_front();
          ck("missing_out_v", g, 0, 1);
        end
        ck("count", g, cnt_w[g], mq[g].size());
        ck("empty", g, 32'(emp_w[g]), 32'(mq[g].size() == 0));
        ck("full", g, 32'(ful_w[g]), 32'(mq[g].size() == dep));
        busy[g] = rdy_w[g] ? 0 : busy[g] + 1;
        if (busy[g] > lim) ck("busy_bound", g, busy[g], lim);
      end
      // Commit what the coming edge will see.
      if (rst) begin
        mq[g].delete();
        eq[g].delete();
      end else if (in_v && rdy_w[g]) begin
        sz = mq[g].size();
        bi = 0;
        for (int k = 1; k < sz; k++)
          if ((g == 0) ? (mq[g][k] > mq[g][bi]) : (mq[g][k] < mq[g][bi])) bi = k;
        e.rd = in_rd; e.err = 1'b0; e.data = '0;
        case (in_op)
          OP_PUSH: if (sz == dep) e.err = 1'b1;
                   else begin mq[g].push_back(in_data); e.data = in_data; end
          OP_POP:  if (sz == 0) e.err = 1'b1;
                   else begin e.data = mq[g][bi]; mq[g].delete(bi); end
          OP_PEEK: if (sz == 0) e.err = 1'b1;
                   else e.data = mq[g][bi];
          default: if (sz == 0) begin e.err = 1'b1; mq[g].push_back(in_data); end
                   else begin e.data = mq[g][bi]; mq[g][bi] = in_data; end
        endcase
        eq[g].push_back(e);
      end
    end
    rst_d = rst;
    if (done && !fin) begin
      fin = 1'b1;
      ck("ready_timeout", 0, 32'(tmo), 0);
      for (int g = 0; g < NG; g++) ck("drain", g, eq[g].size(), 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [1:0] op, input logic [DW-1:0] d, input logic [4:0] rd);
    int n;
    n = 0;
    while (!(&rdy_w) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(&rdy_w)) tmo = 1'b1;
    in_v = 1'b1; in_op = op; in_data = d; in_rd = rd;
    @(posedge clk); #1;
    in_v = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  int t1 [5] = '{5, 17, 3, 42, 8};
  int t2 [5] = '{9, 2, 7, 4, 1};

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    foreach (t1[i]) issue(OP_PUSH, DW'(t1[i]), 5'(i + 1));
    repeat (5) issue(OP_POP, '0, 5'd10);
    repeat (1) issue(OP_POP, '0, 5'd11);

    foreach (t2[i]) issue(OP_PUSH, DW'(t2[i]), 5'(i + 12));
    issue(OP_POP, '0, 5'd17);
    repeat (5) issue(OP_POP, '0, 5'd18);

    issue(OP_POP, '0, 5'd20);
    issue(OP_PEEK, '0, 5'd21);
    issue(OP_REPLACE, DW'(6), 5'd22);
    issue(OP_PEEK, '0, 5'd23);
    issue(OP_POP, '0, 5'd24);

    issue(OP_PUSH, DW'(10), 5'd25);
    issue(OP_PUSH, DW'(20), 5'd26);
    issue(OP_PUSH, DW'(30), 5'd27);
    issue(OP_REPLACE, DW'(5), 5'd28);
    repeat (4) issue(OP_POP, '0, 5'd29);

    for (int i = 0; i < 200; i++)
      issue(($urandom_range(0, 9) < 5) ? OP_PUSH : 2'($urandom_range(1, 3)),
            DW'($urandom_range(0, 15)), 5'($urandom_range(0, 31)));

    in_v = 1'b1;
    for (int i = 0; i < 40; i++) begin
      in_rd = 5'((i % 8) + 1);
      in_op = 2'($urandom_range(0, 3));
      in_data = DW'($urandom_range(0, 15));
      @(posedge clk); #1;
    end
    in_v = 1'b0;

    issue(OP_PEEK, '0, 5'd30);
    pulse_reset();
    issue(OP_PUSH, DW'(10), 5'd1);
    issue(OP_PUSH, DW'(20), 5'd2);
    issue(OP_PUSH, DW'(30), 5'd3);
    issue(OP_PUSH, DW'(40), 5'd4);
    pulse_reset();
    issue(OP_POP, '0, 5'd5);

    repeat (10) @(posedge clk);
    done = 1'b1;
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", chk, errs);
    $finish;
  end

endmodule
